mcpu_mem_tlb: RTL and testbench
===============================

Name: mcpu_mem_tlb

Overview:
- Fully associative translation lookaside buffer sitting directly upstream of the page-table walker.
- Translates virtual page numbers for the memory client in one registered cycle on a hit.
- On a miss, issues a single request to the walker over the tlb2ptw_* interface, fills an entry from the result and returns the translation or a fault.
- One outstanding miss at a time; blocking while a walk is in progress.

Parameters:
ENTRIES, 8, number of TLB entries; power of two, 2..32
IDX_BITS, 3, log2(ENTRIES)

Ports:
clkrst_mem_clk  in  1  clock
clkrst_mem_rst_n  in  1  reset; asynchronous, active-low
tlb_pagedir_base  in  20  page directory base (physical page number); driven straight to the walker
tlb_flush  in  1  single-cycle pulse; invalidates all entries
tlb_re  in  1  lookup request, qualified by tlb_ready
tlb_addr  in  [31:12]  virtual page number to translate
tlb_ready  out  1  high when a lookup can be accepted this cycle
tlb_rvalid  out  1  one-cycle pulse; response outputs valid
tlb_phys_addr  out  [31:12]  translated physical page number
tlb_pagedir_flags  out  4  page directory entry flags[3:0]
tlb_pagetab_flags  out  4  page table entry flags[3:0]
tlb_fault  out  1  translation not present; qualified by tlb_rvalid
tlb2ptw_addr  out  [31:12]  virtual page number to walk
tlb2ptw_re  out  1  walk request
tlb2ptw_pagedir_base  out  20  equals tlb_pagedir_base
tlb2ptw_phys_addr  in  [31:12]  walk result physical page number
tlb2ptw_ready  in  1  walker idle; results valid when it returns high after a request
tlb2ptw_pagetab_flags  in  4  walk result page table flags
tlb2ptw_pagedir_flags  in  4  walk result page directory flags

Behaviour:
- Reset values: all entry valid bits 0; state IDLE; victim pointer 0; tlb_rvalid 0; tlb_fault 0; tlb2ptw_re 0; tlb_phys_addr, tlb2ptw_addr and both flag outputs 0.
- Entry contents: valid, vpn[19:0], ppn[19:0], pd_flags[3:0], pt_flags[3:0].
- tlb_ready = (state == IDLE).

State machine:
- IDLE, with tlb_re:
  - Hit (valid entry with vpn == tlb_addr): registered response next cycle with tlb_rvalid = 1, tlb_fault = 0, stored ppn and flags. Stay in IDLE; back-to-back hits give one response per cycle.
  - Miss: latch tlb_addr into tlb2ptw_addr; go to REQ; no tlb_rvalid.
- REQ: tlb2ptw_re = 1. Hold until tlb2ptw_ready is sampled low, then go to WALK. A stalled walker may keep ready high for many cycles; re stays asserted throughout.
- WALK: tlb2ptw_re = 0. When tlb2ptw_ready is sampled high:
  - Register the response: tlb_rvalid pulses the next cycle; go to IDLE.
  - present = pagedir_flags[0] & pagetab_flags[0].
  - Present: tlb_fault = 0; outputs take the walker values; fill one entry.
  - Not present: tlb_fault = 1; tlb_phys_addr = 0; flags are passed through; no fill. Faults are never cached.
- Victim selection: lowest-index invalid entry if any; otherwise the entry at the victim pointer. The pointer increments, wrapping modulo ENTRIES, only on a fill that used it.
- Duplicates cannot occur: only one miss is outstanding, and the fill is for a VPN that just missed.

Flush:
- tlb_flush clears all valid bits at the next edge.
- A lookup in the same cycle as a flush is treated as a miss.
- A flush during REQ or WALK sets flush_pending. The walk completes and the response is delivered, but no fill is made. flush_pending clears on returning to IDLE.
- Changing tlb_pagedir_base does not flush; software must pulse tlb_flush.

Reset mid-walk: asynchronous return to IDLE with tlb2ptw_re low. The walker shares the same reset domain.

Optional Feature:
MCPU_MEM_TLB_STATS_EN:
- Defined: adds outputs tlb_hit_count[31:0] and tlb_miss_count[31:0]. Reset to 0. They increment on an accepted hit and an accepted miss respectively, saturate at 32'hFFFFFFFF, and are not cleared by tlb_flush.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss then hit:
  - Stimulus: lookup 20'h00400; walker returns ppn 20'h12345, pd 4'h1, pt 4'h3.
  - Required: tlb2ptw_re held until ready drops, then rvalid with phys 20'h12345 and fault 0. A repeat lookup of 20'h00400 gives rvalid exactly 1 cycle after tlb_re, with no walker request.
- Stalled walker:
  - Stimulus: walker holds ready high for 5 cycles after the request.
  - Required: tlb2ptw_re stays 1 for all 5 cycles, drops the cycle after ready is sampled low, and exactly one walk occurs.
- Fault, not cached:
  - Stimulus: walker returns pt flags 4'h0.
  - Required: rvalid with fault 1 and phys 0. The same lookup again issues a new walk.
- Replacement:
  - Stimulus: ENTRIES=8; fill VPNs 0..7, then miss on VPN 8.
  - Required: VPN 8 replaces entry 0. A lookup of VPN 0 misses; VPNs 1..7 hit.
- Flush during walk:
  - Stimulus: pulse tlb_flush in WALK.
  - Required: the response is still delivered, but the same VPN misses afterwards and previously valid VPNs also miss.
- Stats (MCPU_MEM_TLB_STATS_EN defined):
  - Stimulus: 3 hits and 2 misses.
  - Required: tlb_hit_count = 3, tlb_miss_count = 2; both unchanged by tlb_flush.

Source files
------------

// File: rtl/mcpu_mem_tlb.sv
// Fully associative TLB in front of the page-table walker.
// Optional hit/miss counters: define MCPU_MEM_TLB_STATS_EN.
module mcpu_mem_tlb #(
   parameter int ENTRIES  = 8,
   parameter int IDX_BITS = 3
) (
   input  logic          clkrst_mem_clk,
   input  logic          clkrst_mem_rst_n,
   input  logic [19:0]   tlb_pagedir_base,
   input  logic          tlb_flush,
   input  logic          tlb_re,
   input  logic [31:12]  tlb_addr,
   output logic          tlb_ready,
   output logic          tlb_rvalid,
   output logic [31:12]  tlb_phys_addr,
   output logic [3:0]    tlb_pagedir_flags,
   output logic [3:0]    tlb_pagetab_flags,
   output logic          tlb_fault,
   output logic [31:12]  tlb2ptw_addr,
   output logic          tlb2ptw_re,
   output logic [19:0]   tlb2ptw_pagedir_base,
   input  logic [31:12]  tlb2ptw_phys_addr,
   input  logic          tlb2ptw_ready,
   input  logic [3:0]    tlb2ptw_pagetab_flags,
   input  logic [3:0]    tlb2ptw_pagedir_flags
`ifdef MCPU_MEM_TLB_STATS_EN
   ,
   output logic [31:0]   tlb_hit_count,
   output logic [31:0]   tlb_miss_count
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, WALK} state_t;

   typedef struct packed {
      logic        valid;
      logic [19:0] vpn;
      logic [19:0] ppn;
      logic [3:0]  pd_flags;
      logic [3:0]  pt_flags;
   } entry_t;

   state_t              state_q, state_d;
   entry_t              ent_q [ENTRIES];
   entry_t              ent_d [ENTRIES];
   logic [IDX_BITS-1:0] vptr_q, vptr_d;
   logic                flush_pend_q, flush_pend_d;
   logic                rvalid_q, rvalid_d;
   logic                fault_q, fault_d;
   logic [19:0]         phys_q, phys_d;
   logic [3:0]          pdf_q, pdf_d;
   logic [3:0]          ptf_q, ptf_d;
   logic [19:0]         waddr_q, waddr_d;

   logic                hit;
   logic [IDX_BITS-1:0] hit_idx;
   logic                any_free;
   logic [IDX_BITS-1:0] free_idx;
   logic [IDX_BITS-1:0] fill_idx;
   logic                present;
   logic                acc_hit;
   logic                acc_miss;

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (ent_q[i].valid && ent_q[i].vpn == tlb_addr) begin
            hit     = 1'b1;
            hit_idx = IDX_BITS'(i);
         end
      end
   end

   // Descending scan so the lowest free index wins.
   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!ent_q[i].valid) begin
            any_free = 1'b1;
            free_idx = IDX_BITS'(i);
         end
      end
   end

   assign fill_idx = any_free ? free_idx : vptr_q;
   assign present  = tlb2ptw_pagedir_flags[0] & tlb2ptw_pagetab_flags[0];
   assign acc_hit  = (state_q == IDLE) && tlb_re && hit && !tlb_flush;
   assign acc_miss = (state_q == IDLE) && tlb_re && !(hit && !tlb_flush);

   always_comb begin
      state_d      = state_q;
      ent_d        = ent_q;
      vptr_d       = vptr_q;
      flush_pend_d = flush_pend_q;
      rvalid_d     = 1'b0;
      fault_d      = fault_q;
      phys_d       = phys_q;
      pdf_d        = pdf_q;
      ptf_d        = ptf_q;
      waddr_d      = waddr_q;
      if (tlb_flush && state_q != IDLE) flush_pend_d = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (acc_hit) begin
               rvalid_d = 1'b1;
               fault_d  = 1'b0;
               phys_d   = ent_q[hit_idx].ppn;
               pdf_d    = ent_q[hit_idx].pd_flags;
               ptf_d    = ent_q[hit_idx].pt_flags;
            end else if (acc_miss) begin
               waddr_d = tlb_addr;
               state_d = REQ;
            end
         end
         REQ: begin
            if (!tlb2ptw_ready) state_d = WALK;
         end
         WALK: begin
            if (tlb2ptw_ready) begin
               state_d      = IDLE;
               flush_pend_d = 1'b0;
               rvalid_d     = 1'b1;
               fault_d      = !present;
               phys_d       = present ? tlb2ptw_phys_addr : 20'h0;
               pdf_d        = tlb2ptw_pagedir_flags;
               ptf_d        = tlb2ptw_pagetab_flags;
               if (present && !flush_pend_q && !tlb_flush) begin
                  ent_d[fill_idx] = '{1'b1, waddr_q, tlb2ptw_phys_addr,
                                      tlb2ptw_pagedir_flags,
                                      tlb2ptw_pagetab_flags};
                  if (!any_free) vptr_d = vptr_q + IDX_BITS'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (tlb_flush) begin
         for (int i = 0; i < ENTRIES; i++) ent_d[i].valid = 1'b0;
      end
   end

   always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
      if (!clkrst_mem_rst_n) begin
         state_q      <= IDLE;
         for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
         vptr_q       <= '0;
         flush_pend_q <= 1'b0;
         rvalid_q     <= 1'b0;
         fault_q      <= 1'b0;
         phys_q       <= '0;
         pdf_q        <= '0;
         ptf_q        <= '0;
         waddr_q      <= '0;
      end else begin
         state_q      <= state_d;
         ent_q        <= ent_d;
         vptr_q       <= vptr_d;
         flush_pend_q <= flush_pend_d;
         rvalid_q     <= rvalid_d;
         fault_q      <= fault_d;
         phys_q       <= phys_d;
         pdf_q        <= pdf_d;
         ptf_q        <= ptf_d;
         waddr_q      <= waddr_d;
      end
   end

   assign tlb_ready            = (state_q == IDLE);
   assign tlb_rvalid           = rvalid_q;
   assign tlb_fault            = fault_q;
   assign tlb_phys_addr        = phys_q;
   assign tlb_pagedir_flags    = pdf_q;
   assign tlb_pagetab_flags    = ptf_q;
   assign tlb2ptw_addr         = waddr_q;
   assign tlb2ptw_re           = (state_q == REQ);
   assign tlb2ptw_pagedir_base = tlb_pagedir_base;

`ifdef MCPU_MEM_TLB_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (acc_hit && hit_cnt_q != 32'hFFFF_FFFF)
         hit_cnt_d = hit_cnt_q + 32'd1;
      if (acc_miss && miss_cnt_q != 32'hFFFF_FFFF)
         miss_cnt_d = miss_cnt_q + 32'd1;
   end

   always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
      if (!clkrst_mem_rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign tlb_hit_count  = hit_cnt_q;
   assign tlb_miss_count = miss_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = acc_hit ^ acc_miss;
`endif

endmodule

// File: tb/tb_mcpu_mem_tlb.sv
// Directed bench for mcpu_mem_tlb; the walker is modelled inline
// by the lookup task.
module tb_mcpu_mem_tlb;

   logic         clk;
   logic         rst_n;
   logic [19:0]  pd_base;
   logic         tlb_flush;
   logic         tlb_re;
   logic [19:0]  tlb_addr;
   logic         tlb_ready;
   logic         tlb_rvalid;
   logic [19:0]  tlb_phys_addr;
   logic [3:0]   tlb_pagedir_flags;
   logic [3:0]   tlb_pagetab_flags;
   logic         tlb_fault;
   logic [19:0]  ptw_addr;
   logic         ptw_re;
   logic [19:0]  ptw_pd_base;
   logic [19:0]  ptw_phys;
   logic         ptw_ready;
   logic [3:0]   ptw_pt;
   logic [3:0]   ptw_pd;
`ifdef MCPU_MEM_TLB_STATS_EN
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;
`endif

   int n_run;
   int n_fail;
   int walk_cnt;
   int exp_hits;
   int exp_miss;
   int w0;
   logic re_prev;

   mcpu_mem_tlb #(.ENTRIES(8), .IDX_BITS(3)) dut (
      .clkrst_mem_clk        (clk),
      .clkrst_mem_rst_n      (rst_n),
      .tlb_pagedir_base      (pd_base),
      .tlb_flush             (tlb_flush),
      .tlb_re                (tlb_re),
      .tlb_addr              (tlb_addr),
      .tlb_ready             (tlb_ready),
      .tlb_rvalid            (tlb_rvalid),
      .tlb_phys_addr         (tlb_phys_addr),
      .tlb_pagedir_flags     (tlb_pagedir_flags),
      .tlb_pagetab_flags     (tlb_pagetab_flags),
      .tlb_fault             (tlb_fault),
      .tlb2ptw_addr          (ptw_addr),
      .tlb2ptw_re            (ptw_re),
      .tlb2ptw_pagedir_base  (ptw_pd_base),
      .tlb2ptw_phys_addr     (ptw_phys),
      .tlb2ptw_ready         (ptw_ready),
      .tlb2ptw_pagetab_flags (ptw_pt),
      .tlb2ptw_pagedir_flags (ptw_pd)
`ifdef MCPU_MEM_TLB_STATS_EN
      ,
      .tlb_hit_count         (hit_count),
      .tlb_miss_count        (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges of the walk request.
   always @(posedge clk) begin
      if (ptw_re && !re_prev) walk_cnt <= walk_cnt + 1;
      re_prev <= ptw_re;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_flush();
      tlb_flush = 1'b1;
      @(negedge clk);
      tlb_flush = 1'b0;
   endtask

   // Walker values are what a walk of vpn returns; a hit expects the
   // same values that were cached by the original walk.
   task automatic lookup(input logic [19:0] vpn, input bit exp_hit,
                         input logic [19:0] w_ppn,
                         input logic [3:0] w_pd, input logic [3:0] w_pt,
                         input int stall, input bit fl_walk);
      logic        e_fault;
      logic [19:0] e_phys;
      e_fault = !(w_pd[0] & w_pt[0]);
      e_phys  = e_fault ? 20'h0 : w_ppn;
      if (exp_hit) exp_hits++;
      else exp_miss++;
      chk("ready", 32'(tlb_ready), 32'd1);
      tlb_re   = 1'b1;
      tlb_addr = vpn;
      @(negedge clk);
      tlb_re = 1'b0;
      chk("hit", 32'(tlb_rvalid), 32'(exp_hit));
      if (!tlb_rvalid) begin
         chk("req_re", 32'(ptw_re), 32'd1);
         chk("req_addr", 32'(ptw_addr), 32'(vpn));
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_re", 32'(ptw_re), 32'd1);
         end
         ptw_ready = 1'b0;
         @(negedge clk);
         chk("walk_re", 32'(ptw_re), 32'd0);
         if (fl_walk) tlb_flush = 1'b1;
         @(negedge clk);
         tlb_flush = 1'b0;
         chk("walk_busy", 32'(tlb_rvalid), 32'd0);
         ptw_phys  = w_ppn;
         ptw_pd    = w_pd;
         ptw_pt    = w_pt;
         ptw_ready = 1'b1;
         @(negedge clk);
         chk("walk_rvalid", 32'(tlb_rvalid), 32'd1);
      end
      chk("phys", 32'(tlb_phys_addr), 32'(e_phys));
      chk("fault", 32'(tlb_fault), 32'(e_fault));
      chk("pd_flags", 32'(tlb_pagedir_flags), 32'(w_pd));
      chk("pt_flags", 32'(tlb_pagetab_flags), 32'(w_pt));
      @(negedge clk);
      chk("rv_pulse", 32'(tlb_rvalid), 32'd0);
   endtask

   initial begin
      n_run     = 0;
      n_fail    = 0;
      walk_cnt  = 0;
      exp_hits  = 0;
      exp_miss  = 0;
      re_prev   = 1'b0;
      rst_n     = 1'b0;
      pd_base   = 20'hABCDE;
      tlb_flush = 1'b0;
      tlb_re    = 1'b0;
      tlb_addr  = '0;
      ptw_phys  = '0;
      ptw_ready = 1'b1;
      ptw_pt    = '0;
      ptw_pd    = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("rst_ready", 32'(tlb_ready), 32'd1);
      chk("rst_rvalid", 32'(tlb_rvalid), 32'd0);
      chk("rst_fault", 32'(tlb_fault), 32'd0);
      chk("rst_ptw_re", 32'(ptw_re), 32'd0);
      chk("rst_phys", 32'(tlb_phys_addr), 32'd0);
      chk("rst_waddr", 32'(ptw_addr), 32'd0);
      chk("rst_flags", 32'({tlb_pagedir_flags, tlb_pagetab_flags}), 32'd0);
      chk("pd_base", 32'(ptw_pd_base), 32'hABCDE);

      // Cold miss then hit
      lookup(20'h00400, 1'b0, 20'h12345, 4'h1, 4'h3, 0, 1'b0);
      chk("cold_walks", 32'(walk_cnt), 32'd1);
      lookup(20'h00400, 1'b1, 20'h12345, 4'h1, 4'h3, 0, 1'b0);
      chk("hit_nowalk", 32'(walk_cnt), 32'd1);

      // Replacement: fill 0..7, VPN 8 evicts entry 0
      do_flush();
      for (int v = 0; v < 8; v++)
         lookup(20'(v), 1'b0, 20'h80000 | 20'(v), 4'h1, 4'h1, 0, 1'b0);
      lookup(20'd8, 1'b0, 20'h80008, 4'h1, 4'h1, 0, 1'b0);
      for (int v = 1; v < 9; v++)
         lookup(20'(v), 1'b1, 20'h80000 | 20'(v), 4'h1, 4'h1, 0, 1'b0);
      w0 = walk_cnt;
      lookup(20'd0, 1'b0, 20'h80000, 4'h1, 4'h1, 0, 1'b0);
      chk("evict_walk", 32'(walk_cnt - w0), 32'd1);

      // Stalled walker
      do_flush();
      w0 = walk_cnt;
      lookup(20'h00600, 1'b0, 20'h22222, 4'h1, 4'h1, 5, 1'b0);
      chk("stall_walks", 32'(walk_cnt - w0), 32'd1);

      // Fault is not cached
      lookup(20'h00500, 1'b0, 20'hABCDE, 4'h1, 4'h0, 0, 1'b0);
      w0 = walk_cnt;
      lookup(20'h00500, 1'b0, 20'hABCDE, 4'h1, 4'h0, 0, 1'b0);
      chk("fault_rewalk", 32'(walk_cnt - w0), 32'd1);

      // Flush during walk: response delivered, nothing survives
      lookup(20'h00700, 1'b0, 20'h33333, 4'h1, 4'h1, 0, 1'b0);
      lookup(20'h00710, 1'b0, 20'h44444, 4'h3, 4'h5, 0, 1'b1);
      lookup(20'h00710, 1'b0, 20'h44444, 4'h3, 4'h5, 0, 1'b0);
      lookup(20'h00700, 1'b0, 20'h33333, 4'h1, 4'h1, 0, 1'b0);
      lookup(20'h00600, 1'b0, 20'h22222, 4'h1, 4'h1, 0, 1'b0);

      // Lookup coincident with flush is a miss
      tlb_flush = 1'b1;
      tlb_re    = 1'b1;
      tlb_addr  = 20'h00700;
      @(negedge clk);
      tlb_flush = 1'b0;
      tlb_re    = 1'b0;
      exp_miss++;
      chk("flush_lookup", 32'(tlb_rvalid), 32'd0);
      chk("flush_req", 32'(ptw_re), 32'd1);
      ptw_ready = 1'b0;
      @(negedge clk);
      ptw_phys  = 20'h33333;
      ptw_pd    = 4'h1;
      ptw_pt    = 4'h1;
      ptw_ready = 1'b1;
      @(negedge clk);
      chk("flush_resp", 32'(tlb_rvalid), 32'd1);
      @(negedge clk);

`ifdef MCPU_MEM_TLB_STATS_EN
      // 3 hits and 2 misses on top of the running totals
      lookup(20'h00700, 1'b1, 20'h33333, 4'h1, 4'h1, 0, 1'b0);
      lookup(20'h00700, 1'b1, 20'h33333, 4'h1, 4'h1, 0, 1'b0);
      lookup(20'h00900, 1'b0, 20'h55555, 4'h1, 4'h1, 0, 1'b0);
      lookup(20'h00900, 1'b1, 20'h55555, 4'h1, 4'h1, 0, 1'b0);
      lookup(20'h00A00, 1'b0, 20'h66666, 4'h1, 4'h1, 0, 1'b0);
      chk("hit_count", hit_count, 32'(exp_hits));
      chk("miss_count", miss_count, 32'(exp_miss));
      do_flush();
      chk("hit_cnt_flush", hit_count, 32'(exp_hits));
      chk("miss_cnt_flush", miss_count, 32'(exp_miss));
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
